// File: rtl/player_move_ctrl.sv
// rtl/player_move_ctrl.sv - two-player grid movement with auto-repeat, collision blocking and fire pulses (WRAP_EN: wrap axes instead of clamping)
module player_move_ctrl #(
    parameter int TICK_DIV      = 25000,
    parameter int REPEAT_DELAY  = 300,
    parameter int REPEAT_RATE   = 100,
    parameter int FIRE_COOLDOWN = 250,
    parameter int POS_W         = 6,
    parameter int X_MAX         = 39,
    parameter int Y_MAX         = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       p1keys,
    input  logic [4:0]       p2keys,
    output logic [POS_W-1:0] p1_x,
    output logic [POS_W-1:0] p1_y,
    output logic [POS_W-1:0] p2_x,
    output logic [POS_W-1:0] p2_y,
    output logic             p1_fire,
    output logic             p2_fire,
    output logic             move_strobe
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(RMAX + 1);
    localparam int CW = (FIRE_COOLDOWN < 1) ? 1 : $clog2(FIRE_COOLDOWN + 1);
    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0]    DLY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0]    RPT_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [CW-1:0]    CD_INIT   = CW'(FIRE_COOLDOWN);
    localparam logic [POS_W-1:0] XM        = POS_W'(X_MAX);
    localparam logic [POS_W-1:0] YM        = POS_W'(Y_MAX);
`ifdef WRAP_EN
    localparam logic WRAP = 1'b1;
`else
    localparam logic WRAP = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT} state_t;

    logic [TW-1:0]             tick_cnt;
    logic                      tick;
    logic                      primed;
    logic [1:0][4:0]           keys;
    logic [1:0][4:0]           prev;
    logic [1:0][3:0]           rise;
    logic [1:0]                fire_rise;
    state_t                    state   [2];
    state_t                    st_nxt  [2];
    logic [RW-1:0]             rcnt    [2];
    logic [RW-1:0]             cnt_nxt [2];
    logic [CW-1:0]             cd      [2];
    logic [1:0]                req;
    logic [1:0]                fire_q;
    logic [1:0][POS_W-1:0]     px, py, tx, ty;
    logic                      mv1, mv2;

    // One-step move along an axis; inc/dec both set cancels the axis.
    function automatic logic [POS_W-1:0] step_axis(input logic [POS_W-1:0] p, input logic inc,
                                                   input logic dec, input logic [POS_W-1:0] mx);
        step_axis = p;
        if (inc && !dec)
            step_axis = (p == mx) ? (WRAP ? '0 : mx) : p + 1'b1;
        else if (dec && !inc)
            step_axis = (p == '0) ? (WRAP ? mx : '0) : p - 1'b1;
    endfunction

    assign keys = {p2keys, p1keys};
    assign tick = (tick_cnt == TICK_LAST);

    // Edges are suppressed until prev has been loaded once after reset, so a held key never counts.
    for (genvar g = 0; g < 2; g++) begin : g_player
        assign rise[g]      = keys[g][3:0] & ~prev[g][3:0] & {4{primed}};
        assign fire_rise[g] = keys[g][4] & ~prev[g][4] & primed;
        assign tx[g]        = step_axis(px[g], keys[g][3], keys[g][2], XM);
        assign ty[g]        = step_axis(py[g], keys[g][1], keys[g][0], YM);
    end

    assign mv1 = req[0] && ({tx[0], ty[0]} != {px[0], py[0]}) && ({tx[0], ty[0]} != {px[1], py[1]});
    assign mv2 = req[1] && ({tx[1], ty[1]} != {px[1], py[1]}) && ({tx[1], ty[1]} != {px[0], py[0]})
                 && !(mv1 && ({tx[1], ty[1]} == {tx[0], ty[0]}));

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            st_nxt[i]  = state[i];
            cnt_nxt[i] = rcnt[i];
            req[i]     = 1'b0;
            case (state[i])
                S_IDLE: begin
                    if (|rise[i]) begin
                        req[i]     = 1'b1;
                        st_nxt[i]  = S_DELAY;
                        cnt_nxt[i] = '0;
                    end
                end
                S_DELAY: begin
                    if (keys[i][3:0] == 4'd0) begin
                        st_nxt[i]  = S_IDLE;
                        cnt_nxt[i] = '0;
                    end else if (|rise[i]) begin
                        req[i]     = 1'b1;
                        cnt_nxt[i] = '0;
                    end else if (tick) begin
                        if (rcnt[i] == DLY_LAST) begin
                            req[i]     = 1'b1;
                            st_nxt[i]  = S_REPEAT;
                            cnt_nxt[i] = '0;
                        end else begin
                            cnt_nxt[i] = rcnt[i] + 1'b1;
                        end
                    end
                end
                S_REPEAT: begin
                    if (keys[i][3:0] == 4'd0) begin
                        st_nxt[i]  = S_IDLE;
                        cnt_nxt[i] = '0;
                    end else if (|rise[i]) begin
                        req[i]     = 1'b1;
                        st_nxt[i]  = S_DELAY;
                        cnt_nxt[i] = '0;
                    end else if (tick) begin
                        if (rcnt[i] == RPT_LAST) begin
                            req[i]     = 1'b1;
                            cnt_nxt[i] = '0;
                        end else begin
                            cnt_nxt[i] = rcnt[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    st_nxt[i]  = S_IDLE;
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt    <= '0;
            primed      <= 1'b0;
            prev        <= '0;
            px[0]       <= '0;
            py[0]       <= '0;
            px[1]       <= XM;
            py[1]       <= YM;
            move_strobe <= 1'b0;
            fire_q      <= '0;
            for (int i = 0; i < 2; i++) begin
                state[i] <= S_IDLE;
                rcnt[i]  <= '0;
                cd[i]    <= '0;
            end
        end else begin
            tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
            primed      <= 1'b1;
            prev        <= keys;
            move_strobe <= mv1 | mv2;
            if (mv1) begin
                px[0] <= tx[0];
                py[0] <= ty[0];
            end
            if (mv2) begin
                px[1] <= tx[1];
                py[1] <= ty[1];
            end
            for (int i = 0; i < 2; i++) begin
                state[i] <= st_nxt[i];
                rcnt[i]  <= cnt_nxt[i];
                if (fire_rise[i] && cd[i] == '0) begin
                    fire_q[i] <= 1'b1;
                    cd[i]     <= CD_INIT;
                end else begin
                    fire_q[i] <= 1'b0;
                    if (tick && cd[i] != '0)
                        cd[i] <= cd[i] - 1'b1;
                end
            end
        end
    end

    assign p1_x    = px[0];
    assign p1_y    = py[0];
    assign p2_x    = px[1];
    assign p2_y    = py[1];
    assign p1_fire = fire_q[0];
    assign p2_fire = fire_q[1];
endmodule

// File: tb/tb_player_move_ctrl.sv
// tb/tb_player_move_ctrl.sv - directed-vector bench for player_move_ctrl
module tb_player_move_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] p1keys = 5'd0, p2keys = 5'd0;
    logic [5:0] p1_x, p1_y, p2_x, p2_y;
    logic       p1_fire, p2_fire, move_strobe;
    int         cyc;
    int         n_tests = 0, n_fail = 0;
    int         p0;
`ifdef WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    player_move_ctrl #(
        .TICK_DIV(4), .REPEAT_DELAY(3), .REPEAT_RATE(2), .FIRE_COOLDOWN(5),
        .POS_W(6), .X_MAX(7), .Y_MAX(7)
    ) dut (
        .clk(clk), .rst_n(rst_n), .p1keys(p1keys), .p2keys(p2keys),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_fire(p1_fire), .p2_fire(p2_fire), .move_strobe(move_strobe)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        p1keys = 5'd0;
        p2keys = 5'd0;
        clk_n(2);
        rst_n = 1'b1;
        clk_n(1);
    endtask

    task automatic press_p1(input string tag, input logic [4:0] k, input int ex, input int ey, input int es);
        p1keys = k;
        clk_n(1);
        check({tag, "_x"}, int'(p1_x), ex);
        check({tag, "_y"}, int'(p1_y), ey);
        check({tag, "_strobe"}, int'(move_strobe), es);
        p1keys = 5'd0;
        clk_n(1);
    endtask

    initial begin
        clk_n(2);
        check("rst_p1x", int'(p1_x), 0);
        check("rst_p1y", int'(p1_y), 0);
        check("rst_p2x", int'(p2_x), 7);
        check("rst_p2y", int'(p2_y), 7);
        check("rst_fire", int'({p1_fire, p2_fire}), 0);
        check("rst_strobe", int'(move_strobe), 0);
        rst_n = 1'b1;
        clk_n(1);

        // single tap right
        press_p1("tap", 5'b01000, 1, 0, 1);
        check("tap_strobe_off", int'(move_strobe), 0);
        check("tap_p2x", int'(p2_x), 7);
        check("tap_p2y", int'(p2_y), 7);

        // held right, press aligned to a tick clock
        do_reset();
        while (cyc % 4 != 3) clk_n(1);
        p1keys = 5'b01000;
        p0 = cyc + 1;
        wait_to(p0);
        check("hold_t0_x", int'(p1_x), 1);
        check("hold_t0_strobe", int'(move_strobe), 1);
        wait_to(p0 + 11);
        check("hold_pre_delay_x", int'(p1_x), 1);
        wait_to(p0 + 12);
        check("hold_delay_x", int'(p1_x), 2);
        check("hold_delay_strobe", int'(move_strobe), 1);
        wait_to(p0 + 19);
        check("hold_pre_rate_x", int'(p1_x), 2);
        wait_to(p0 + 20);
        check("hold_rate_x", int'(p1_x), 3);
        wait_to(p0 + 52);
        check("hold_edge_x", int'(p1_x), 7);
        wait_to(p0 + 60);
        check("hold_clamp_x", int'(p1_x), WRAP ? 0 : 7);
        check("hold_clamp_strobe", int'(move_strobe), WRAP ? 1 : 0);
        p1keys = 5'd0;
        clk_n(1);
        if (WRAP) press_p1("wrap_back", 5'b00100, 7, 0, 1);

        // walk down the right edge into p2
        for (int i = 1; i <= 6; i++) press_p1("down", 5'b00010, 7, i, 1);
        press_p1("coll_down", 5'b00010, 7, 6, 0);
        press_p1("left", 5'b00100, 6, 6, 1);
        press_p1("down67", 5'b00010, 6, 7, 1);
        press_p1("coll_right", 5'b01000, 6, 7, 0);

        // opposing keys cancel, diagonal moves
        press_p1("diag1", 5'b00101, 5, 6, 1);
        press_p1("diag2", 5'b00101, 4, 5, 1);
        press_p1("diag3", 5'b00101, 3, 4, 1);
        press_p1("up33", 5'b00001, 3, 3, 1);
        press_p1("cancel", 5'b00011, 3, 3, 0);
        press_p1("upleft", 5'b00101, 2, 2, 1);

        p2keys = 5'b00100;
        clk_n(1);
        check("p2_left_x", int'(p2_x), 6);
        check("p2_left_y", int'(p2_y), 7);
        p2keys = 5'd0;
        clk_n(1);

        // fire cooldown
        p2keys = 5'b10000;
        clk_n(1);
        check("fire1", int'(p2_fire), 1);
        check("fire1_p1", int'(p1_fire), 0);
        p2keys = 5'd0;
        clk_n(1);
        check("fire1_end", int'(p2_fire), 0);
        clk_n(6);
        p2keys = 5'b10000;
        clk_n(1);
        check("fire2_dropped", int'(p2_fire), 0);
        check("fire_no_move", int'(p2_x), 6);
        p2keys = 5'd0;
        clk_n(21);
        p2keys = 5'b10000;
        clk_n(1);
        check("fire3", int'(p2_fire), 1);
        p2keys = 5'd0;
        clk_n(1);

        // reset mid-hold
        do_reset();
        p1keys = 5'b01000;
        clk_n(1);
        check("rh_move", int'(p1_x), 1);
        rst_n = 1'b0;
        clk_n(1);
        check("rh_reset_x", int'(p1_x), 0);
        rst_n = 1'b1;
        clk_n(20);
        check("rh_held_x", int'(p1_x), 0);
        check("rh_held_strobe", int'(move_strobe), 0);
        p1keys = 5'd0;
        clk_n(1);
        press_p1("rh_repress", 5'b01000, 1, 0, 1);

        // left at x=0
        do_reset();
        press_p1("left_edge", 5'b00100, WRAP ? 7 : 0, 0, WRAP ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
